char_mem_scheduler: RTL and testbench
=====================================

// Module: char_mem_scheduler
// PURPOSE
//  Time-slot scheduler for the single-port character/font BRAM (codes + glyphs, 13-bit addr).
//  Each 8-pixel slot (pix_phase 0..7) gives phase 0 to video code fetch and phase 1 to video glyph fetch.
//  Phases 2..7 are shared round-robin between the CPU byte port and a built-in clear/scroll engine.
//  Replaces the CPU stall-until-phase-3 scheme with a req/ack port and hardware screen scrolling.
// PARAMETERS
//  COLS       100     text columns per row
//  ROWS       36      text rows; rows 36/37 overlap font data and are never written by the engine
//  FONT_BASE  3088    glyph address = {code[6:0],glyph_row} + FONT_BASE (3584-31*16)
//  FILL_CHAR  8'h20   byte written by clear / scroll fill
// PORTS
//  clk           in   1   pixel/system clock, 50 MHz
//  reset_button  in   1   reset, asynchronous, active-low
//  pix_phase     in   3   xpos[2:0]
//  text_col      in   7   xpos[9:3]
//  text_row      in   6   ypos[9:4]
//  glyph_row     in   4   ypos[3:0]
//  mem_addr      out  13  BRAM address, combinational from phase and grant
//  mem_we        out  1   BRAM write enable (byte)
//  mem_wdata     out  8   BRAM write data
//  mem_rdata     in   8   BRAM registered read data; valid 1 cycle after mem_addr
//  cpu_req       in   1   CPU access request; held with addr/we/wdata stable until cpu_ack
//  cpu_we        in   1   1 = write, 0 = read
//  cpu_addr      in   13  byte address
//  cpu_wdata     in   8   write byte
//  cpu_ack       out  1   1-cycle pulse: write performed / cpu_rdata valid
//  cpu_rdata     out  8   read byte, held until next read ack
//  cmd_valid     in   1   engine command strobe
//  cmd_op        in   2   01 clear screen, 10 scroll up one row; 00/11 no-op
//  cmd_ready     out  1   1 when engine idle
//  busy          out  1   engine operation in progress
// BEHAVIOUR
//  Reset: all regs clear; cpu_ack=0, cpu_rdata=0, mem_we=0, busy=0, cmd_ready=1, rr pointer = CPU first.
//  Phase 0: mem_addr = text_col + COLS*text_row (13-bit), mem_we=0. Phase 1: glyph addr from mem_rdata; mem_we=0.
//  Phases 2..7: grant one requester; both pending -> the one NOT granted last; single pending -> it.
//  No grant in phases 0/1 under any condition; mem_we is 0 whenever nobody is granted.
//  CPU write: mem_we=1 in grant cycle, cpu_ack same cycle. CPU read: addr in grant cycle t, cpu_ack+cpu_rdata at t+1.
//  CPU read outstanding (t+1 pending): no new CPU grant that cycle; engine may take it.
//  Read granted at phase 7 returns at next phase 0; captured before video data arrives at phase 1.
//  Engine FSM: IDLE -> (clear) FILL | (scroll) RD -> WR -> RD ... -> FILL -> IDLE.
//   RD: read idx+COLS; data latched into hold reg next cycle. WR: write hold reg to idx, idx++.
//   Copy covers idx 0..COLS*(ROWS-1)-1; FILL writes FILL_CHAR to last row (scroll) or 0..COLS*ROWS-1 (clear).
//   Each RD/WR/FILL step consumes one granted slot; FSM advances only on grant.
//  cmd_valid accepted only when cmd_ready; op 00/11 consumed with no effect; cmd_valid while busy ignored.
//  busy rises cycle after acceptance, falls cycle after last FILL write; cmd_ready = ~busy.
//  Async reset mid-operation aborts immediately; partial copy left in BRAM, FSM IDLE.
//  Worst-case CPU latency with engine active: 4 cycles (write), 5 (read).
// STRUCTURE
//  Package char_mem_pkg: PH_CODE=0, PH_GLYPH=1, OP_CLEAR=2'b01, OP_SCROLL=2'b10, FONT_BASE, engine state enum.
//  Sub-module scroll_engine: FSM, idx counter, hold reg; exposes req/we/addr/wdata, takes grant+rdata.
//  Top: phase decoder, round-robin arbiter, address mux, CPU read-return register.
// TESTING
//  Idle, sweep pix_phase 0..7, col=5,row=2, rdata=0x41 at phase1 -> addr 205, then 0x410+glyph_row+3088.
//  CPU write 0x0C8<=0x58 asserted at phase 0 -> mem_we only at phase 2, cpu_ack same cycle, never phase 0/1.
//  CPU read 0x010 granted phase 7, rdata 0x33 -> cpu_ack at next phase 0, cpu_rdata=0x33.
//  Scroll, CPU idle: addr 100 read then addr 0 written with same byte; last row 3500..3599 = 0x20; busy clears.
//  Scroll + continuous CPU reads -> grants alternate CPU/engine in phases 2..7; no starvation.
//  reset_button low mid-clear -> busy=0, cmd_ready=1, mem_we=0 immediately; new clear accepted after release.

Source files
------------

// File: rtl/char_mem_pkg.sv
// ---------------------------------------------------------------------------
// char_mem_pkg
//   Shared constants and types for the character/font BRAM scheduler.
//   PH_CODE / PH_GLYPH  : pixel phases reserved for video code / glyph fetch
//   OP_CLEAR / OP_SCROLL: engine command encodings
//   FONT_BASE           : default glyph table offset (3584 - 31*16)
//   eng_state_e         : clear/scroll engine states
//   glyph_addr()        : video glyph address from fetched code and row
// ---------------------------------------------------------------------------
package char_mem_pkg;

   localparam logic [2:0]  PH_CODE   = 3'd0;
   localparam logic [2:0]  PH_GLYPH  = 3'd1;
   localparam logic [1:0]  OP_CLEAR  = 2'b01;
   localparam logic [1:0]  OP_SCROLL = 2'b10;
   localparam int unsigned FONT_BASE = 3088;

   typedef enum logic [1:0] {
      ENG_IDLE,
      ENG_RD,
      ENG_WR,
      ENG_FILL
   } eng_state_e;

   // Glyph rows are stored 16 per code; only 7 code bits select a glyph.
   function automatic logic [12:0] glyph_addr(input logic [7:0]  code,
                                              input logic [3:0]  row,
                                              input int unsigned base);
      return 13'({code[6:0], row}) + 13'(base);
   endfunction

endpackage

// File: rtl/char_mem_scheduler_if.sv
// ---------------------------------------------------------------------------
// char_mem_scheduler_if
//   CPU byte port of the character BRAM scheduler (req/ack handshake).
//   cpu_req   : request, held with cpu_we/cpu_addr/cpu_wdata stable until ack
//   cpu_we    : 1 = write, 0 = read
//   cpu_addr  : 13-bit byte address
//   cpu_wdata : write byte
//   cpu_ack   : one-cycle pulse, write done / cpu_rdata valid
//   cpu_rdata : read byte, held until the next read ack
//   master = CPU side, slave = scheduler side.
// ---------------------------------------------------------------------------
interface char_mem_scheduler_if;

   logic        cpu_req;
   logic        cpu_we;
   logic [12:0] cpu_addr;
   logic [7:0]  cpu_wdata;
   logic        cpu_ack;
   logic [7:0]  cpu_rdata;

   modport master (
      output cpu_req, cpu_we, cpu_addr, cpu_wdata,
      input  cpu_ack, cpu_rdata
   );

   modport slave (
      input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
      output cpu_ack, cpu_rdata
   );

endinterface

// File: rtl/char_mem_scheduler_scroll_engine.sv
// ---------------------------------------------------------------------------
// scroll_engine
//   Hardware clear-screen / scroll-up-one-row engine for the text BRAM.
//   Each RD/WR/FILL step waits for a granted slot from the scheduler.
//   Ports:
//     clk, reset_button : clock, async active-low reset
//     cmd_valid, cmd_op : command strobe / opcode (01 clear, 10 scroll)
//     cmd_ready, busy   : idle indication / operation in progress
//     req, we, addr,
//     wdata             : memory request towards the arbiter
//     gnt               : slot granted this cycle
//     rdata             : BRAM registered read data
// ---------------------------------------------------------------------------
module scroll_engine #(
   parameter int unsigned COLS      = 100,
   parameter int unsigned ROWS      = 36,
   parameter logic [7:0]  FILL_CHAR = 8'h20
) (
   input  logic        clk,
   input  logic        reset_button,
   input  logic        cmd_valid,
   input  logic [1:0]  cmd_op,
   output logic        cmd_ready,
   output logic        busy,
   output logic        req,
   output logic        we,
   output logic [12:0] addr,
   output logic [7:0]  wdata,
   input  logic        gnt,
   input  logic [7:0]  rdata
);
   import char_mem_pkg::*;

   localparam logic [12:0] COPY_LAST = 13'(COLS * (ROWS - 1) - 1);
   localparam logic [12:0] FILL_LAST = 13'(COLS * ROWS - 1);

   eng_state_e  state_q, state_d;
   logic [12:0] idx_q, idx_d;
   logic [7:0]  hold_q, hold_d;
   logic        wait_q, wait_d;

   always_ff @(posedge clk or negedge reset_button) begin
      if (!reset_button) begin
         state_q <= ENG_IDLE;
         idx_q   <= '0;
         hold_q  <= '0;
         wait_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         hold_q  <= hold_d;
         wait_q  <= wait_d;
      end
   end

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      hold_d  = hold_q;
      wait_d  = 1'b0;
      req     = 1'b0;
      we      = 1'b0;
      addr    = idx_q;
      wdata   = FILL_CHAR;

      // Read data arrives the cycle after the granted RD; capture it here.
      if (wait_q) begin
         hold_d = rdata;
      end

      unique case (state_q)
         ENG_IDLE: begin
            if (cmd_valid) begin
               if (cmd_op == OP_CLEAR) begin
                  state_d = ENG_FILL;
                  idx_d   = '0;
               end else if (cmd_op == OP_SCROLL) begin
                  state_d = ENG_RD;
                  idx_d   = '0;
               end
            end
         end
         ENG_RD: begin
            req  = 1'b1;
            addr = idx_q + 13'(COLS);
            if (gnt) begin
               wait_d  = 1'b1;
               state_d = ENG_WR;
            end
         end
         ENG_WR: begin
            // Hold off the write request until the hold register is loaded.
            req   = !wait_q;
            we    = 1'b1;
            wdata = hold_q;
            if (gnt) begin
               idx_d   = idx_q + 13'd1;
               state_d = (idx_q == COPY_LAST) ? ENG_FILL : ENG_RD;
            end
         end
         ENG_FILL: begin
            req = 1'b1;
            we  = 1'b1;
            if (gnt) begin
               if (idx_q == FILL_LAST) begin
                  state_d = ENG_IDLE;
               end else begin
                  idx_d = idx_q + 13'd1;
               end
            end
         end
         default: state_d = ENG_IDLE;
      endcase
   end

   assign busy      = (state_q != ENG_IDLE);
   assign cmd_ready = !busy;

endmodule

// File: rtl/char_mem_scheduler.sv
// ---------------------------------------------------------------------------
// char_mem_scheduler
//   Time-slot scheduler for the single-port character/font BRAM.
//   Phase 0: video code fetch, phase 1: video glyph fetch, phases 2..7:
//   round-robin between the CPU byte port and the clear/scroll engine.
//   Ports:
//     clk, reset_button          : clock, async active-low reset
//     pix_phase, text_col,
//     text_row, glyph_row        : video timing/position
//     mem_addr, mem_we,
//     mem_wdata, mem_rdata       : BRAM port (rdata registered, 1-cycle)
//     cpu                        : CPU req/ack port (slave modport)
//     cmd_valid, cmd_op,
//     cmd_ready, busy            : clear/scroll engine control
// ---------------------------------------------------------------------------
module char_mem_scheduler #(
   parameter int unsigned COLS      = 100,
   parameter int unsigned ROWS      = 36,
   parameter int unsigned FONT_BASE = 3088,
   parameter logic [7:0]  FILL_CHAR = 8'h20
) (
   input  logic                 clk,
   input  logic                 reset_button,
   input  logic [2:0]           pix_phase,
   input  logic [6:0]           text_col,
   input  logic [5:0]           text_row,
   input  logic [3:0]           glyph_row,
   output logic [12:0]          mem_addr,
   output logic                 mem_we,
   output logic [7:0]           mem_wdata,
   input  logic [7:0]           mem_rdata,
   char_mem_scheduler_if.slave  cpu,
   input  logic                 cmd_valid,
   input  logic [1:0]           cmd_op,
   output logic                 cmd_ready,
   output logic                 busy
);
   import char_mem_pkg::*;

   logic        slot_open;
   logic        cpu_pend;
   logic        cpu_gnt;
   logic        eng_gnt;
   logic        eng_req;
   logic        eng_we;
   logic [12:0] eng_addr;
   logic [7:0]  eng_wdata;
   logic [12:0] vid_addr;

   logic        rd_pend_q, rd_pend_d;
   logic [7:0]  rdata_q, rdata_d;
   logic        last_cpu_q, last_cpu_d;

   scroll_engine #(
      .COLS      (COLS),
      .ROWS      (ROWS),
      .FILL_CHAR (FILL_CHAR)
   ) u_engine (
      .clk          (clk),
      .reset_button (reset_button),
      .cmd_valid    (cmd_valid),
      .cmd_op       (cmd_op),
      .cmd_ready    (cmd_ready),
      .busy         (busy),
      .req          (eng_req),
      .we           (eng_we),
      .addr         (eng_addr),
      .wdata        (eng_wdata),
      .gnt          (eng_gnt),
      .rdata        (mem_rdata)
   );

   assign slot_open = (pix_phase != PH_CODE) && (pix_phase != PH_GLYPH);
   assign vid_addr  = 13'(text_col) + 13'(COLS) * 13'(text_row);

   always_ff @(posedge clk or negedge reset_button) begin
      if (!reset_button) begin
         rd_pend_q  <= 1'b0;
         rdata_q    <= '0;
         last_cpu_q <= 1'b0;
      end else begin
         rd_pend_q  <= rd_pend_d;
         rdata_q    <= rdata_d;
         last_cpu_q <= last_cpu_d;
      end
   end

   // Round-robin arbiter; the CPU is still holding req during its read
   // return cycle, so it is masked until the ack has been delivered.
   always_comb begin
      cpu_pend = cpu.cpu_req && !rd_pend_q;
      cpu_gnt  = 1'b0;
      eng_gnt  = 1'b0;
      if (slot_open) begin
         if (cpu_pend && eng_req) begin
            if (last_cpu_q) eng_gnt = 1'b1;
            else            cpu_gnt = 1'b1;
         end else if (cpu_pend) begin
            cpu_gnt = 1'b1;
         end else if (eng_req) begin
            eng_gnt = 1'b1;
         end
      end
   end

   always_comb begin
      last_cpu_d = last_cpu_q;
      if (cpu_gnt)      last_cpu_d = 1'b1;
      else if (eng_gnt) last_cpu_d = 1'b0;
      rd_pend_d = cpu_gnt && !cpu.cpu_we;
      rdata_d   = rd_pend_q ? mem_rdata : rdata_q;
   end

   // Read return is presented combinationally from the BRAM in the ack cycle
   // and held in rdata_q afterwards.
   assign cpu.cpu_ack   = (cpu_gnt && cpu.cpu_we) || rd_pend_q;
   assign cpu.cpu_rdata = rd_pend_q ? mem_rdata : rdata_q;

   always_comb begin
      mem_addr  = '0;
      mem_we    = 1'b0;
      mem_wdata = '0;
      if (pix_phase == PH_CODE) begin
         mem_addr = vid_addr;
      end else if (pix_phase == PH_GLYPH) begin
         mem_addr = glyph_addr(mem_rdata, glyph_row, FONT_BASE);
      end else if (cpu_gnt) begin
         mem_addr  = cpu.cpu_addr;
         mem_we    = cpu.cpu_we;
         mem_wdata = cpu.cpu_wdata;
      end else if (eng_gnt) begin
         mem_addr  = eng_addr;
         mem_we    = eng_we;
         mem_wdata = eng_wdata;
      end
   end

endmodule

// File: tb/tb_char_mem_scheduler.sv
module tb_char_mem_scheduler;

   logic        clk = 1'b0;
   logic        reset_button;
   logic [2:0]  pix_phase;
   logic [6:0]  text_col;
   logic [5:0]  text_row;
   logic [3:0]  glyph_row;
   logic [12:0] mem_addr;
   logic        mem_we;
   logic [7:0]  mem_wdata;
   logic [7:0]  mem_rdata;
   logic        cmd_valid;
   logic [1:0]  cmd_op;
   logic        cmd_ready;
   logic        busy;

   char_mem_scheduler_if cif ();

   char_mem_scheduler #(
      .COLS      (100),
      .ROWS      (36),
      .FONT_BASE (3088),
      .FILL_CHAR (8'h20)
   ) dut (
      .clk          (clk),
      .reset_button (reset_button),
      .pix_phase    (pix_phase),
      .text_col     (text_col),
      .text_row     (text_row),
      .glyph_row    (glyph_row),
      .mem_addr     (mem_addr),
      .mem_we       (mem_we),
      .mem_wdata    (mem_wdata),
      .mem_rdata    (mem_rdata),
      .cpu          (cif),
      .cmd_valid    (cmd_valid),
      .cmd_op       (cmd_op),
      .cmd_ready    (cmd_ready),
      .busy         (busy)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;
   int viol     = 0;

   // Background pattern; two addresses carry the bytes the directed cases need.
   function automatic logic [7:0] pat(input int unsigned a);
      logic [12:0] x;
      x = a[12:0];
      if (a == 205) return 8'h41;
      if (a == 16)  return 8'h33;
      return x[7:0] ^ {3'b000, x[12:8]} ^ 8'h5A;
   endfunction

   // BRAM model: registered read, read-before-write.
   logic [7:0] bram [0:8191];
   logic       load_pat = 1'b0;
   always @(posedge clk) begin
      if (load_pat) begin
         for (int i = 0; i < 8192; i++) bram[i] <= pat(i);
      end else if (mem_we) begin
         bram[mem_addr] <= mem_wdata;
      end
      mem_rdata <= bram[mem_addr];
   end

   initial begin
      pix_phase = 3'd0;
      forever begin
         @(posedge clk);
         #1 pix_phase = pix_phase + 3'd1;
      end
   end

   always @(negedge clk) begin
      if (reset_button === 1'b1 && mem_we === 1'b1 && pix_phase < 3'd2) viol++;
   end

   initial begin
      #3_000_000;
      $display("FAIL watchdog: got timeout, required $finish");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h required 0x%0h", tag, got, exp);
      end
   endtask

   task automatic wait_phase(input logic [2:0] p);
      int k = 0;
      @(negedge clk);
      while (pix_phase !== p && k < 16) begin
         @(negedge clk);
         k++;
      end
      check("wait_phase", pix_phase, p);
   endtask

   task automatic load_mem();
      @(negedge clk) load_pat = 1'b1;
      @(negedge clk) load_pat = 1'b0;
   endtask

   task automatic issue_cmd(input logic [1:0] op);
      @(negedge clk);
      cmd_valid = 1'b1;
      cmd_op    = op;
      @(posedge clk);
      #1 cmd_valid = 1'b0;
   endtask

   task automatic wait_engine_done(input string tag);
      bit seen = 1'b0;
      for (int k = 0; k < 40000 && !seen; k++) begin
         @(negedge clk);
         if (mem_we && mem_addr == 13'd3599) begin
            seen = 1'b1;
            check({tag, "_busy_last"}, busy, 1);
            @(negedge clk);
            check({tag, "_busy_clr"}, busy, 0);
            check({tag, "_ready"}, cmd_ready, 1);
         end
      end
      check({tag, "_done"}, seen, 1);
   endtask

   task automatic verify_mem(input string tag, input int shift, input int fill_lo);
      int bad_copy = 0;
      int bad_fill = 0;
      int bad_font = 0;
      for (int a = 0; a < fill_lo; a++)    if (bram[a] !== pat(a + shift)) bad_copy++;
      for (int a = fill_lo; a < 3600; a++) if (bram[a] !== 8'h20)          bad_fill++;
      for (int a = 3600; a < 7680; a++)    if (bram[a] !== pat(a))         bad_font++;
      check({tag, "_copy_bad"}, bad_copy, 0);
      check({tag, "_fill_bad"}, bad_fill, 0);
      check({tag, "_font_bad"}, bad_font, 0);
   endtask

   int  lat, max_rd, max_wr, bad_rd, to_cnt, cpu_g, eng_g, k;
   bit  acked, cpu_done;

   initial begin
      reset_button  = 1'b0;
      cmd_valid     = 1'b0;
      cmd_op        = 2'b00;
      text_col      = 7'd5;
      text_row      = 6'd2;
      glyph_row     = 4'd3;
      cif.cpu_req   = 1'b0;
      cif.cpu_we    = 1'b0;
      cif.cpu_addr  = '0;
      cif.cpu_wdata = '0;

      // Reset state
      repeat (3) @(negedge clk);
      check("rst_ack",   cif.cpu_ack, 0);
      check("rst_rdata", cif.cpu_rdata, 0);
      check("rst_we",    mem_we, 0);
      check("rst_busy",  busy, 0);
      check("rst_ready", cmd_ready, 1);
      reset_button = 1'b1;
      load_mem();

      // Video fetch sweep, col 5 row 2, code 0x41 -> 0x410 + 3 + 3088
      wait_phase(3'd0);
      check("vid_code_addr", mem_addr, 205);
      check("vid_code_we",   mem_we, 0);
      @(negedge clk);
      check("vid_rdata",      mem_rdata, 8'h41);
      check("vid_glyph_addr", mem_addr, 4131);
      check("vid_glyph_we",   mem_we, 0);
      for (int p = 2; p < 8; p++) begin
         @(negedge clk);
         check("vid_idle_we", mem_we, 0);
      end

      // CPU write asserted in phase 0 -> performed in phase 2
      wait_phase(3'd0);
      cif.cpu_req = 1'b1; cif.cpu_we = 1'b1; cif.cpu_addr = 13'h0C8; cif.cpu_wdata = 8'h58;
      #1;
      check("wr_ph0_we",  mem_we, 0);
      check("wr_ph0_ack", cif.cpu_ack, 0);
      @(negedge clk);
      check("wr_ph1_we",   mem_we, 0);
      check("wr_ph1_ack",  cif.cpu_ack, 0);
      check("wr_ph1_addr", mem_addr, 4131);
      @(negedge clk);
      check("wr_ph2_we",    mem_we, 1);
      check("wr_ph2_addr",  mem_addr, 13'h0C8);
      check("wr_ph2_wdata", mem_wdata, 8'h58);
      check("wr_ph2_ack",   cif.cpu_ack, 1);
      @(posedge clk);
      #1 cif.cpu_req = 1'b0; cif.cpu_we = 1'b0;
      @(negedge clk);
      check("wr_bram",     bram[200], 8'h58);
      check("wr_ack_drop", cif.cpu_ack, 0);

      // CPU read granted in phase 7 -> returns at phase 0
      wait_phase(3'd7);
      cif.cpu_req = 1'b1; cif.cpu_we = 1'b0; cif.cpu_addr = 13'h010;
      #1;
      check("rd7_addr", mem_addr, 13'h010);
      check("rd7_we",   mem_we, 0);
      check("rd7_ack",  cif.cpu_ack, 0);
      @(negedge clk);
      check("rd0_ack",   cif.cpu_ack, 1);
      check("rd0_rdata", cif.cpu_rdata, 8'h33);
      check("rd0_addr",  mem_addr, 205);
      @(posedge clk);
      #1 cif.cpu_req = 1'b0;
      @(negedge clk);
      check("rd1_ack",   cif.cpu_ack, 0);
      check("rd1_hold",  cif.cpu_rdata, 8'h33);
      check("rd1_glyph", mem_addr, 4131);

      // Read at phase 2: return cycle must not re-grant the still-requesting CPU
      wait_phase(3'd2);
      cif.cpu_req = 1'b1; cif.cpu_we = 1'b0; cif.cpu_addr = 13'h1F05;
      #1;
      check("rd2_addr", mem_addr, 13'h1F05);
      @(negedge clk);
      check("rd3_ack",   cif.cpu_ack, 1);
      check("rd3_rdata", cif.cpu_rdata, 8'h40);
      check("rd3_addr",  mem_addr, 0);
      @(posedge clk);
      #1 cif.cpu_req = 1'b0;

      // Scroll with CPU idle
      load_mem();
      @(negedge clk);
      check("scr_ready", cmd_ready, 1);
      issue_cmd(2'b10);
      @(negedge clk);
      check("scr_busy", busy, 1);
      k = 0;
      while (pix_phase < 3'd2 && k < 8) begin @(negedge clk); k++; end
      check("scr_rd_addr", mem_addr, 100);
      check("scr_rd_we",   mem_we, 0);
      k = 0;
      do begin @(negedge clk); k++; end while (!mem_we && k < 16);
      check("scr_wr_addr",  mem_addr, 0);
      check("scr_wr_wdata", mem_wdata, 8'h3E);
      wait_engine_done("scr");
      verify_mem("scr", 100, 3500);

      // Scroll with back-to-back CPU traffic
      load_mem();
      issue_cmd(2'b10);
      max_rd = 0; max_wr = 0; bad_rd = 0; to_cnt = 0; cpu_g = 0; eng_g = 0;
      cpu_done = 1'b0;
      fork
         begin
            @(posedge clk);
            #1;
            for (int t = 0; t < 40; t++) begin
               cif.cpu_req   = 1'b1;
               cif.cpu_we    = (t == 39);
               cif.cpu_addr  = 13'h1E00 + 13'(t);
               cif.cpu_wdata = 8'hC3;
               lat = 0; acked = 1'b0;
               while (!acked && lat < 20) begin
                  @(negedge clk);
                  lat++;
                  if (cif.cpu_ack) acked = 1'b1;
               end
               if (!acked) to_cnt++;
               else if (t == 39) begin
                  if (lat > max_wr) max_wr = lat;
               end else begin
                  if (lat > max_rd) max_rd = lat;
                  if (cif.cpu_rdata !== pat(32'h1E00 + t)) bad_rd++;
               end
               @(posedge clk);
               #1;
            end
            cif.cpu_req = 1'b0;
            cif.cpu_we  = 1'b0;
            cpu_done    = 1'b1;
         end
         begin
            while (!cpu_done) begin
               @(negedge clk);
               if (pix_phase >= 3'd2) begin
                  if (mem_addr >= 13'h1E00)           cpu_g++;
                  else if (mem_we || mem_addr != '0)  eng_g++;
               end
            end
         end
      join
      check("mix_timeouts",  to_cnt, 0);
      check("mix_rd_data",   bad_rd, 0);
      check("mix_rd_lat_le5", max_rd <= 5, 1);
      check("mix_wr_lat_le4", max_wr <= 4, 1);
      check("mix_cpu_grants", cpu_g, 40);
      check("mix_eng_grants", eng_g >= 10, 1);
      check("mix_busy",       busy, 1);
      wait_engine_done("mix");
      verify_mem("mix", 100, 3500);
      check("mix_wr_bram", bram[13'h1E27], 8'hC3);

      // Reset mid-clear, no-op command, full clear
      load_mem();
      issue_cmd(2'b01);
      repeat (500) @(negedge clk);
      check("clr_mid_busy", busy, 1);
      reset_button = 1'b0;
      #1;
      check("clr_rst_busy",  busy, 0);
      check("clr_rst_ready", cmd_ready, 1);
      check("clr_rst_we",    mem_we, 0);
      @(negedge clk);
      @(negedge clk) reset_button = 1'b1;
      check("clr_part_head", bram[0], 8'h20);
      check("clr_part_tail", bram[3599], pat(3599));
      issue_cmd(2'b00);
      @(negedge clk);
      check("nop_busy",  busy, 0);
      check("nop_ready", cmd_ready, 1);
      issue_cmd(2'b01);
      @(negedge clk);
      check("clr_busy", busy, 1);
      wait_engine_done("clr");
      verify_mem("clr", 0, 0);

      check("we_in_ph01", viol, 0);
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
